// File: rtl/gat_layer_sequencer_if.sv
// Handshake bundle between the GAT run controller and its environment:
// PS run request, BRAM load status, conv1/conv2 launch/completion and
// run status/statistics.
interface gat_layer_sequencer_if #(
  parameter int unsigned NUM_SUBGRAPHS = 2708,
  parameter int unsigned CYC_CNT_W     = 32
);
  localparam int unsigned SG_CNT_W = $clog2(NUM_SUBGRAPHS + 1);

  logic                 start;
  logic                 h_data_bram_load_done;
  logic                 h_node_info_bram_load_done;
  logic                 wgt_bram_load_done;
  logic                 conv1_start;
  logic                 conv1_sg_done;
  logic                 conv1_done;
  logic                 conv2_start;
  logic                 conv2_sg_done;
  logic                 conv2_done;
  logic                 gat_layer;
  logic                 busy;
  logic                 done;
  logic [SG_CNT_W-1:0]  sg_count;
  logic [CYC_CNT_W-1:0] cycle_count;
  logic                 sg_mismatch;

  // Sequencer side
  modport slave (
    input  start, h_data_bram_load_done, h_node_info_bram_load_done,
           wgt_bram_load_done, conv1_sg_done, conv1_done,
           conv2_sg_done, conv2_done,
    output conv1_start, conv2_start, gat_layer, busy, done,
           sg_count, cycle_count, sg_mismatch
  );

  // PS / conv-engine side
  modport master (
    output start, h_data_bram_load_done, h_node_info_bram_load_done,
           wgt_bram_load_done, conv1_sg_done, conv1_done,
           conv2_sg_done, conv2_done,
    input  conv1_start, conv2_start, gat_layer, busy, done,
           sg_count, cycle_count, sg_mismatch
  );
endinterface

// File: rtl/gat_layer_sequencer.sv
// Top-level run controller for the two-layer GAT pipeline.
// Waits for the BRAM loads, runs conv1, drains, flips the shared-port mux
// (gat_layer) and runs conv2, counting subgraphs and active cycles.
module gat_layer_sequencer #(
  parameter int unsigned NUM_SUBGRAPHS = 2708,
  parameter int unsigned DRAIN_CYCLES  = 4,
  parameter int unsigned CYC_CNT_W     = 32
) (
  input logic                  clk,
  input logic                  rst,
  gat_layer_sequencer_if.slave bus
);
  localparam int unsigned SG_CNT_W = $clog2(NUM_SUBGRAPHS + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_LOAD = 3'd1;
  localparam logic [2:0] S_CONV1     = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_CONV2     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [SG_CNT_W-1:0]  SG_MAX     = '1;
  localparam logic [SG_CNT_W-1:0]  SG_TARGET  = SG_CNT_W'(NUM_SUBGRAPHS);
  localparam logic [CYC_CNT_W-1:0] CYC_MAX    = '1;
  localparam logic [7:0]           DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [7:0]           drain_cnt;
  logic [SG_CNT_W-1:0]  sg_count;
  logic [CYC_CNT_W-1:0] cycle_count;
  logic                 sg_mismatch;
  logic                 busy;
  logic                 done;
  logic                 gat_layer;
  logic                 conv1_start;
  logic                 conv2_start;

  logic                 in_conv;
  logic                 run_start;
  logic                 loads_ready;
  logic                 sg_pulse;
  logic                 layer_end;
  logic [SG_CNT_W-1:0]  sg_final;

  // Decode the events that matter in the current state; pulses belonging to
  // the other layer or arriving outside a CONV state are masked here.
  always_comb begin
    in_conv     = (state == S_CONV1) || (state == S_CONV2) || (state == S_DRAIN);
    run_start   = bus.start && ((state == S_IDLE) || (state == S_DONE));
    loads_ready = bus.h_data_bram_load_done && bus.h_node_info_bram_load_done &&
                  bus.wgt_bram_load_done;
    sg_pulse    = ((state == S_CONV1) && bus.conv1_sg_done) ||
                  ((state == S_CONV2) && bus.conv2_sg_done);
    layer_end   = ((state == S_CONV1) && bus.conv1_done) ||
                  ((state == S_CONV2) && bus.conv2_done);
    // A sg_done coincident with the layer's done is counted before the check
    sg_final    = sg_count;
    if (sg_pulse && (sg_count != SG_MAX)) begin
      sg_final = sg_count + 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (run_start)                state_next = S_WAIT_LOAD;
      S_WAIT_LOAD:    if (loads_ready)              state_next = S_CONV1;
      S_CONV1:        if (layer_end)                state_next = S_DRAIN;
      S_DRAIN:        if (drain_cnt == DRAIN_LAST)  state_next = S_CONV2;
      S_CONV2:        if (layer_end)                state_next = S_DONE;
      default:                                      state_next = S_IDLE;
    endcase
  end

  // State register and drain timer (restarts at 0 on each DRAIN entry)
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == S_DRAIN) begin
        drain_cnt <= drain_cnt + 8'd1;
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  // Subgraph counter, active-cycle counter and sticky mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sg_count    <= '0;
      cycle_count <= '0;
      sg_mismatch <= 1'b0;
    end else if (run_start) begin
      sg_count    <= '0;
      cycle_count <= '0;
      sg_mismatch <= 1'b0;
    end else begin
      if (in_conv && (cycle_count != CYC_MAX)) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (layer_end && (sg_final != SG_TARGET)) begin
        sg_mismatch <= 1'b1;
      end
      // Leaving CONV1 clears the count for conv2; leaving CONV2 keeps the final
      if ((state == S_CONV1) && layer_end) begin
        sg_count <= '0;
      end else begin
        sg_count <= sg_final;
      end
    end
  end

  // Status and launch outputs registered from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      gat_layer   <= 1'b0;
      conv1_start <= 1'b0;
      conv2_start <= 1'b0;
    end else begin
      busy        <= (state_next == S_WAIT_LOAD) || (state_next == S_CONV1) ||
                     (state_next == S_DRAIN)     || (state_next == S_CONV2);
      done        <= (state_next == S_DONE);
      gat_layer   <= (state_next == S_CONV2) || (state_next == S_DONE);
      conv1_start <= (state_next == S_CONV1) && (state != S_CONV1);
      conv2_start <= (state_next == S_CONV2) && (state != S_CONV2);
    end
  end

  assign bus.conv1_start = conv1_start;
  assign bus.conv2_start = conv2_start;
  assign bus.gat_layer   = gat_layer;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.sg_count    = sg_count;
  assign bus.cycle_count = cycle_count;
  assign bus.sg_mismatch = sg_mismatch;
endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Testbench for gat_layer_sequencer: directed vector table, hand-written
// corner sequences and a randomized phase, all checked cycle by cycle.
module tb_gat_layer_sequencer;
  localparam int unsigned NSG    = 4;
  localparam int unsigned DRAIN  = 3;
  localparam int unsigned SG_MAX = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  gat_layer_sequencer_if #(.NUM_SUBGRAPHS(NSG), .CYC_CNT_W(32)) bus ();

  gat_layer_sequencer #(
    .NUM_SUBGRAPHS(NSG),
    .DRAIN_CYCLES (DRAIN),
    .CYC_CNT_W    (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Input vector bits: {rst, start, ld_h, ld_n, ld_w, c1sg, c1d, c2sg, c2d}
  // Output vector: {conv1_start, conv2_start, gat_layer, busy, done,
  //                 sg_mismatch, sg_count[2:0], cycle_count[31:0]}
  typedef struct {
    logic [8:0] in;
    logic [5:0] flags;
    int         sg;
    int         cyc;
  } vec_t;

  // Reference model: run phase 0 idle, 1 wait-load, 2 conv1, 3 drain,
  // 4 conv2, 5 done; age = cycles already spent in the current phase.
  int          m_phase = 0;
  int          m_age   = 0;
  int          m_sg    = 0;
  logic [31:0] m_cyc   = '0;
  bit          m_mm    = 0;
  bit          m_c1s   = 0;
  bit          m_c2s   = 0;

  task automatic model_step(input logic [8:0] in);
    int prev;
    if (in[8]) begin
      m_phase = 0; m_age = 0; m_sg = 0; m_cyc = '0;
      m_mm = 0; m_c1s = 0; m_c2s = 0;
    end else begin
      prev = m_phase;
      if (m_phase >= 2 && m_phase <= 4 && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      case (m_phase)
        0, 5: if (in[7]) begin m_phase = 1; m_sg = 0; m_cyc = '0; m_mm = 0; end
        1: if (in[6] && in[5] && in[4]) m_phase = 2;
        2: begin
          if (in[3]) m_sg = (m_sg < SG_MAX) ? m_sg + 1 : SG_MAX;
          if (in[2]) begin
            if (m_sg != NSG) m_mm = 1;
            m_sg = 0;
            m_phase = 3;
          end
        end
        3: if (m_age == DRAIN - 1) m_phase = 4;
        4: begin
          if (in[1]) m_sg = (m_sg < SG_MAX) ? m_sg + 1 : SG_MAX;
          if (in[0]) begin
            if (m_sg != NSG) m_mm = 1;
            m_phase = 5;
          end
        end
        default: m_phase = 0;
      endcase
      m_age = (m_phase == prev) ? m_age + 1 : 0;
      m_c1s = (m_phase == 2) && (prev != 2);
      m_c2s = (m_phase == 4) && (prev != 4);
    end
  endtask

  function automatic logic [40:0] model_vec();
    logic gat, busy, done;
    gat  = (m_phase == 4) || (m_phase == 5);
    busy = (m_phase >= 1) && (m_phase <= 4);
    done = (m_phase == 5);
    return {m_c1s, m_c2s, gat, busy, done, m_mm, 3'(m_sg), m_cyc};
  endfunction

  function automatic logic [40:0] dut_vec();
    return {bus.conv1_start, bus.conv2_start, bus.gat_layer, bus.busy, bus.done,
            bus.sg_mismatch, bus.sg_count, bus.cycle_count};
  endfunction

  task automatic chk(input string name, input logic [40:0] act, input logic [40:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model and compare all outputs
  task automatic drive(input logic [8:0] in);
    rst                            = in[8];
    bus.start                      = in[7];
    bus.h_data_bram_load_done      = in[6];
    bus.h_node_info_bram_load_done = in[5];
    bus.wgt_bram_load_done         = in[4];
    bus.conv1_sg_done              = in[3];
    bus.conv1_done                 = in[2];
    bus.conv2_sg_done              = in[1];
    bus.conv2_done                 = in[0];
    @(posedge clk);
    #1;
    model_step(in);
    chk("model", dut_vec(), model_vec());
  endtask

  localparam logic [8:0] RST  = 9'b1_0_111_0000;
  localparam logic [8:0] IDL  = 9'b0_0_111_0000;
  localparam logic [8:0] STA  = 9'b0_1_111_0000;
  localparam logic [8:0] C1SG = 9'b0_0_111_1000;
  localparam logic [8:0] C1D  = 9'b0_0_111_0100;
  localparam logic [8:0] C1B  = 9'b0_0_111_1100;
  localparam logic [8:0] C2SG = 9'b0_0_111_0010;
  localparam logic [8:0] C2D  = 9'b0_0_111_0001;
  localparam logic [8:0] C2B  = 9'b0_0_111_0011;

  vec_t tbl[17];

  initial begin
    logic [8:0] rin;

    bus.start = 1'b0;
    bus.h_data_bram_load_done = 1'b0;
    bus.h_node_info_bram_load_done = 1'b0;
    bus.wgt_bram_load_done = 1'b0;
    bus.conv1_sg_done = 1'b0;
    bus.conv1_done = 1'b0;
    bus.conv2_sg_done = 1'b0;
    bus.conv2_done = 1'b0;

    // Nominal run then re-run from DONE; flags = {c1s, c2s, gat, busy, done, mm}
    tbl[0]  = '{RST,  6'b000000, 0, 0};
    tbl[1]  = '{STA,  6'b000100, 0, 0};
    tbl[2]  = '{IDL,  6'b100100, 0, 0};
    tbl[3]  = '{C1SG, 6'b000100, 1, 1};
    tbl[4]  = '{C1SG, 6'b000100, 2, 2};
    tbl[5]  = '{C1SG, 6'b000100, 3, 3};
    tbl[6]  = '{C1SG, 6'b000100, 4, 4};
    tbl[7]  = '{C1D,  6'b000100, 0, 5};
    tbl[8]  = '{IDL,  6'b000100, 0, 6};
    tbl[9]  = '{IDL,  6'b000100, 0, 7};
    tbl[10] = '{IDL,  6'b011100, 0, 8};
    tbl[11] = '{C2SG, 6'b001100, 1, 9};
    tbl[12] = '{C2SG, 6'b001100, 2, 10};
    tbl[13] = '{C2SG, 6'b001100, 3, 11};
    tbl[14] = '{C2B,  6'b001010, 4, 12};
    tbl[15] = '{IDL,  6'b001010, 4, 12};
    tbl[16] = '{STA,  6'b000100, 0, 0};

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].in);
      chk($sformatf("table[%0d]", i), dut_vec(),
          {tbl[i].flags, 3'(tbl[i].sg), 32'(tbl[i].cyc)});
    end

    // Late weight load: no conv1_start while wgt_bram_load_done is low
    drive(RST);
    drive(9'b0_1_110_0000);
    for (int i = 0; i < 20; i++) begin
      drive(9'b0_0_110_0000);
      chk("late_no_start", 41'(bus.conv1_start), 41'(0));
    end
    drive(IDL);
    chk("late_conv1_start", 41'(bus.conv1_start), 41'(1));
    chk("late_cyc_zero", 41'(bus.cycle_count), 41'(0));
    // 4th sg_done coincides with conv1_done: no mismatch
    for (int i = 0; i < 3; i++) drive(C1SG);
    drive(C1B);
    chk("coinc_no_mm", 41'(bus.sg_mismatch), 41'(0));
    for (int i = 0; i < DRAIN; i++) drive(IDL);
    chk("late_conv2_start", 41'(bus.conv2_start), 41'(1));
    // Only 3 subgraphs in conv2
    for (int i = 0; i < 3; i++) drive(C2SG);
    drive(C2D);
    chk("short_mm", 41'({bus.sg_mismatch, bus.done}), 41'(2'b11));
    chk("late_cyc", 41'(bus.cycle_count), 41'(11));

    // Ignored events in CONV1 and DRAIN
    drive(RST);
    drive(STA);
    drive(IDL);
    drive(STA);
    drive(C2D);
    drive(C2SG);
    chk("ign_conv1", 41'({bus.busy, bus.gat_layer, bus.sg_count}), 41'(5'b10000));
    drive(C1SG);
    drive(C1SG);
    drive(C1D);
    drive(C1SG);
    drive(C2B);
    chk("ign_drain_sg", 41'(bus.sg_count), 41'(0));
    drive(C1D);
    chk("ign_drain_conv2", 41'({bus.conv2_start, bus.gat_layer}), 41'(2'b11));
    chk("ign_drain_mm", 41'(bus.sg_mismatch), 41'(1));
    drive(C2SG);
    drive(C2SG);
    // Reset mid-CONV2
    drive(RST);
    chk("rst_mid", dut_vec(), 41'(0));
    drive(STA);
    drive(IDL);
    chk("rerun_gat0", 41'({bus.conv1_start, bus.gat_layer}), 41'(2'b10));
    for (int i = 0; i < 4; i++) drive(C1SG);
    drive(C1D);
    for (int i = 0; i < DRAIN; i++) drive(IDL);
    for (int i = 0; i < 4; i++) drive(C2SG);
    drive(C2D);
    chk("rerun_done", 41'({bus.done, bus.sg_mismatch, bus.sg_count}), 41'(5'b10100));

    // Randomized traffic against the reference model
    drive(RST);
    for (int i = 0; i < 3000; i++) begin
      rin[8] = ($urandom_range(0, 149) == 0);
      rin[7] = ($urandom_range(0, 5) == 0);
      rin[6] = ($urandom_range(0, 3) != 0);
      rin[5] = ($urandom_range(0, 3) != 0);
      rin[4] = ($urandom_range(0, 3) != 0);
      rin[3] = $urandom_range(0, 1) == 1;
      rin[2] = ($urandom_range(0, 7) == 0);
      rin[1] = $urandom_range(0, 1) == 1;
      rin[0] = ($urandom_range(0, 7) == 0);
      drive(rin);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
